line_write_buffer: RTL and testbench

- Single-entry write-back buffer between the cache's physical-memory port and physical memory.
- Absorbs a dirty-line eviction in 2 cycles so the cache can go straight on to its line fill.
- Drains the buffered line to memory in the background and keeps read/write ordering to the same line coherent.
- Cache-side ports mirror the pmem handshake, so the cache connects to it with no changes.

---
 rtl/line_write_buffer.sv | 135 +++++++++++++
 tb/tb_line_write_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_write_buffer.sv
// line_write_buffer: single-entry write-back buffer that sits between the
// cache's pmem port and physical memory. A dirty-line eviction is absorbed
// in two cycles (IDLE capture + ACK) and drained to memory in the
// background. Read/write ordering to the buffered line stays coherent.
//
// Handshake contract (both sides): a request (read/write) is held high until
// the matching one-cycle resp pulse; the requester drops it on the edge that
// ends the resp cycle. pmem_read and pmem_write are never high together.
//
// Optional feature, macro LINE_WRITE_BUFFER_FWD_EN: when defined, a read
// that hits the buffered line is served from the buffer without touching
// memory. When undefined, such a read first drains the line and then reads
// it back from memory (same data, longer latency).
module line_write_buffer #(
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [ADDR_W-1:0] c_address,
  input  logic [LINE_W-1:0] c_wdata,
  output logic [LINE_W-1:0] c_rdata,
  output logic              c_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int TAG_W = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    MEM_READ = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic               valid;
  logic [TAG_W-1:0]   tag;
  logic [LINE_W-1:0]  data;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               unused_offset;

  assign req_tag = c_address[ADDR_W-1:OFFSET_W];
  // The line offset never matters here: the buffer works on whole lines.
  assign unused_offset = ^c_address[OFFSET_W-1:0];
  // Hit compare also decides miss-read vs drain-first, so it exists in both builds.
  assign hit = valid && (req_tag == tag);

  // State register; async reset abandons any in-flight memory transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state selection; IDLE priorities: capture, forward, miss read, drain.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (c_write && !valid)      state_nx = ACK;
`ifdef LINE_WRITE_BUFFER_FWD_EN
        else if (c_read && hit)     state_nx = ACK;
`endif
        else if (c_read && !hit)    state_nx = MEM_READ;
        else if (valid)             state_nx = DRAIN;
        else                        state_nx = IDLE;
      end
      ACK:      state_nx = IDLE;
      MEM_READ: if (pmem_resp) state_nx = ACK;
      DRAIN:    if (pmem_resp) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Buffer storage and returned read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      tag     <= '0;
      data    <= '0;
      c_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (c_write && !valid) begin
            valid <= 1'b1;
            tag   <= req_tag;
            data  <= c_wdata;
          end
`ifdef LINE_WRITE_BUFFER_FWD_EN
          else if (c_read && hit) begin
            c_rdata <= data;
          end
`endif
        end
        MEM_READ: if (pmem_resp) c_rdata <= pmem_rdata;
        DRAIN:    if (pmem_resp) valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Handshake outputs decoded straight from state so reset clears them at once.
  always_comb begin
    c_resp       = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state)
      ACK: c_resp = 1'b1;
      MEM_READ: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, {OFFSET_W{1'b0}}};
      end
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = {tag, {OFFSET_W{1'b0}}};
        pmem_wdata   = data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_write_buffer.sv
// Bench for line_write_buffer: random and directed cache traffic against a
// coherent-memory reference (last write to a line wins), a latency-randomised
// memory model, and a scoreboard monitor that checks every c_resp.
module tb_line_write_buffer;
  localparam int ADDR_W   = 16;
  localparam int LINE_W   = 128;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = ADDR_W - OFFSET_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              c_read, c_write;
  logic [ADDR_W-1:0] c_address;
  logic [LINE_W-1:0] c_wdata, c_rdata;
  logic              c_resp;
  logic              pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata, pmem_rdata;
  logic              pmem_resp;

  line_write_buffer #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_W(OFFSET_W)) dut (
    .clk(clk), .rst(rst),
    .c_read(c_read), .c_write(c_write), .c_address(c_address),
    .c_wdata(c_wdata), .c_rdata(c_rdata), .c_resp(c_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // bench state
  logic [LINE_W-1:0] mem     [1<<TAG_W];  // physical memory contents
  logic [LINE_W-1:0] ref_mem [1<<TAG_W];  // architectural view the cache should see
  logic [LINE_W:0]   exp_q[$];            // {is_read, expected data}
  logic [ADDR_W:0]   log_q[$];            // {is_write, address} of memory transactions
  int n_checks = 0;
  int n_pass   = 0;
  int force_lat = -1;

  function automatic logic [LINE_W-1:0] init_line(input int t);
    return {32'hA500_0000 | 32'(t), 32'(t) * 32'd7, 32'hC3C3_0000 + 32'(t), ~32'(t)};
  endfunction

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_log(input string name, input int idx, input logic [ADDR_W:0] exp);
    if (idx >= log_q.size()) begin
      n_checks++;
      $display("FAIL %s: memory log has %0d entries, wanted entry %0d = %h", name, log_q.size(), idx, exp);
    end else begin
      check(name, LINE_W'(log_q[idx]), LINE_W'(exp));
    end
  endtask

  // memory model: accepts a request, waits a random latency, pulses pmem_resp
  initial begin : mem_model
    bit pending;
    bit cur_w;
    logic [TAG_W-1:0] cur_tag;
    int cnt;
    pending = 0;
    cur_w = 0;
    cur_tag = '0;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (rst) begin
        pending = 0;
      end else if (pending) begin
        if (cnt == 0) begin
          pmem_resp = 1'b1;
          pending = 0;
          if (cur_w) mem[cur_tag] = pmem_wdata;
          else       pmem_rdata = mem[cur_tag];
        end else begin
          cnt--;
        end
      end else if (pmem_read || pmem_write) begin
        pending = 1;
        cur_w   = pmem_write;
        cur_tag = pmem_address[ADDR_W-1:OFFSET_W];
        log_q.push_back({pmem_write, pmem_address});
        cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      end
    end
  end

  // scoreboard monitor: pops one expectation per c_resp; memory-side protocol checks
  always @(negedge clk) begin
    logic [LINE_W:0] e;
    if (!rst) begin
      if (c_resp) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp: c_resp with empty scoreboard, c_rdata %h", c_rdata);
        end else begin
          e = exp_q.pop_front();
          if (e[LINE_W]) check("read_data", c_rdata, e[LINE_W-1:0]);
        end
      end
      if (pmem_read || pmem_write) begin
        check("pmem_exclusive", LINE_W'(pmem_read & pmem_write), '0);
        check("pmem_offset_zero", LINE_W'(pmem_address[OFFSET_W-1:0]), '0);
      end
    end
  end

  // driver: issue one request, hold until c_resp, drop on the edge ending c_resp
  task automatic do_req(input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [LINE_W-1:0] d, output int lat);
    bit seen;
    if (wr) begin
      ref_mem[addr[ADDR_W-1:OFFSET_W]] = d;
      exp_q.push_back({1'b0, d});
    end else begin
      exp_q.push_back({1'b1, ref_mem[addr[ADDR_W-1:OFFSET_W]]});
    end
    c_read    = !wr;
    c_write   = wr;
    c_address = addr;
    c_wdata   = wr ? d : {4{$urandom}};
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (c_resp) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL req_timeout: no c_resp for addr %h within 200 cycles, required one", addr);
      void'(exp_q.pop_back());
    end
    @(posedge clk);
    #1;
    c_read  = 1'b0;
    c_write = 1'b0;
  endtask

  // wait until memory side has been quiet long enough that any drain is done
  task automatic settle();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (!pmem_read && !pmem_write && !pmem_resp) quiet++;
      else quiet = 0;
      if (quiet >= 3) break;
    end
    if (quiet < 3) begin
      n_checks++;
      $display("FAIL settle_timeout: memory side still busy after 300 cycles, required idle");
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // main sequence
  initial begin
    int lat;
    int nmis;
    logic [LINE_W-1:0] d1, d2, d3, d4, dr;
    logic [ADDR_W-1:0] a;
    bit found;

    for (int t = 0; t < (1 << TAG_W); t++) begin
      mem[t]     = init_line(t);
      ref_mem[t] = init_line(t);
    end
    rst = 1'b1;
    c_read = 1'b0;
    c_write = 1'b0;
    c_address = '0;
    c_wdata = '0;
    #1;
    check("reset_c_resp",       LINE_W'(c_resp), '0);
    check("reset_pmem_read",    LINE_W'(pmem_read), '0);
    check("reset_pmem_write",   LINE_W'(pmem_write), '0);
    check("reset_c_rdata",      c_rdata, '0);
    check("reset_pmem_address", LINE_W'(pmem_address), '0);
    check("reset_pmem_wdata",   pmem_wdata, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // write into empty buffer, then background drain
    d1 = rand_line();
    log_q.delete();
    do_req(1'b1, 16'h1234, d1, lat);
    check("write_empty_cycles", LINE_W'(lat + 1), LINE_W'(2));
    settle();
    check("drain_count", LINE_W'(log_q.size()), LINE_W'(1));
    check_log("drain_addr", 0, {1'b1, 16'h1230});
    check("drain_data", mem[12'h123], d1);

    // reset in the middle of a drain abandons the buffered line
    force_lat = 10;
    d4 = rand_line();
    do_req(1'b1, 16'h1234, d4, lat);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (pmem_write) begin
        found = 1;
        break;
      end
    end
    check("drain_started", LINE_W'(found), LINE_W'(1));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_pmem_write", LINE_W'(pmem_write), '0);
    check("rst_mid_pmem_read",  LINE_W'(pmem_read), '0);
    check("rst_mid_c_resp",     LINE_W'(c_resp), '0);
    ref_mem[12'h123] = mem[12'h123];
    @(negedge clk);
    rst = 1'b0;
    force_lat = -1;
    @(posedge clk);
    #1;
    log_q.delete();
    do_req(1'b0, 16'h1234, '0, lat);
    settle();
    check("rst_then_read_count", LINE_W'(log_q.size()), LINE_W'(1));
    check_log("rst_then_read_addr", 0, {1'b0, 16'h1230});

    // full buffer, miss read goes to memory before the drain
    d1 = rand_line();
    log_q.delete();
    do_req(1'b1, 16'h1234, d1, lat);
    do_req(1'b0, 16'h5678, '0, lat);
    settle();
    check_log("miss_read_first", 0, {1'b0, 16'h5670});
    check_log("miss_then_drain", 1, {1'b1, 16'h1230});

    // full buffer, read of the buffered line
    d1 = rand_line();
    log_q.delete();
    do_req(1'b1, 16'h1234, d1, lat);
    do_req(1'b0, 16'h123A, '0, lat);
`ifdef LINE_WRITE_BUFFER_FWD_EN
    check("fwd_read_cycles", LINE_W'(lat + 1), LINE_W'(2));
    check("fwd_no_pmem", LINE_W'(log_q.size()), '0);
    settle();
`else
    settle();
    check_log("hit_drain_first", 0, {1'b1, 16'h1230});
    check_log("hit_then_read",   1, {1'b0, 16'h1230});
`endif

    // second write while full stalls behind the first drain
    d1 = rand_line();
    d2 = rand_line();
    log_q.delete();
    do_req(1'b1, 16'h1234, d1, lat);
    do_req(1'b1, 16'h2000, d2, lat);
    settle();
    check_log("wfull_drain1", 0, {1'b1, 16'h1230});
    check_log("wfull_drain2", 1, {1'b1, 16'h2000});
    check("wfull_mem1", mem[12'h123], d1);
    check("wfull_mem2", mem[12'h200], d2);

    // slow drain with a read waiting behind it
    force_lat = 10;
    d3 = rand_line();
    log_q.delete();
    do_req(1'b1, 16'h4440, d3, lat);
    @(posedge clk);
    #1;
    do_req(1'b0, 16'h5550, '0, lat);
    settle();
    force_lat = -1;
    check_log("slow_drain_first", 0, {1'b1, 16'h4440});
    check_log("slow_read_after",  1, {1'b0, 16'h5550});

    // randomized traffic over a small set of lines
    for (int n = 0; n < 150; n++) begin
      a  = {12'h100 | 12'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      dr = rand_line();
      do_req(1'($urandom_range(0, 1)), a, dr, lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    settle();

    // end-of-run: memory holds the architectural contents, scoreboard drained
    nmis = 0;
    for (int t = 0; t < (1 << TAG_W); t++) begin
      if (mem[t] !== ref_mem[t]) nmis++;
    end
    check("final_mem_mismatches", LINE_W'(nmis), '0);
    check("scoreboard_empty", LINE_W'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
